config_master: RTL and testbench

//   Initiator end of the Valid/Addr/Data configuration bus. It queues configuration

---
 rtl/config_master.sv | 186 ++++++++++++++++++
 tb/tb_config_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/config_master.sv
// -----------------------------------------------------------------------------
// config_master
//   Initiator end of the Valid/Addr/Data configuration bus. Write requests are
//   queued in a small FIFO and each one goes out as a single-cycle Valid strobe.
//   For writes to ACK_ADDR the master waits for the target's Ack (Load_config)
//   or times out. Every write is followed by an enforced idle gap.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous reset, active high
//   i_req_valid  request present
//   o_req_ready  queue can accept (not full)
//   i_req_addr   request target address
//   i_req_data   request write data
//   o_valid      bus strobe, one cycle per write
//   o_addr       bus address, held from issue until the next issue
//   o_data       bus data, held like o_addr
//   i_ack        target load acknowledge
//   o_done       one-cycle pulse: write completed
//   o_err        one-cycle pulse: ack timeout
//   o_busy       FSM not idle
//   o_pending    entries currently queued
// -----------------------------------------------------------------------------
module config_master #(
    parameter int unsigned              CONFIG_WIDTH = 2,
    parameter int unsigned              FIFO_DEPTH   = 4,
    parameter logic [CONFIG_WIDTH-1:0]  ACK_ADDR     = 2'b10,
    parameter int unsigned              ACK_TIMEOUT  = 16,
    parameter int unsigned              GAP_CYCLES   = 2,
    localparam int unsigned             PEND_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [CONFIG_WIDTH-1:0] i_req_addr,
    input  logic [CONFIG_WIDTH-1:0] i_req_data,
    output logic                    o_valid,
    output logic [CONFIG_WIDTH-1:0] o_addr,
    output logic [CONFIG_WIDTH-1:0] o_data,
    input  logic                    i_ack,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    o_busy,
    output logic [PEND_W-1:0]       o_pending
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StGap
    } state_e;

    state_e                        r_state, w_state_next;
    logic [2*CONFIG_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              r_wr_ptr, r_rd_ptr;
    logic [PEND_W-1:0]             r_count;
    logic [CONFIG_WIDTH-1:0]       r_addr, r_data;
    logic [TO_W-1:0]               r_to_cnt, w_to_cnt_next;
    logic [GAP_W-1:0]              r_gap_cnt, w_gap_cnt_next;
    logic                          r_done, r_err;
    logic                          w_done_next, w_err_next;
    logic                          w_full, w_empty, w_push, w_pop;

    assign w_full  = (r_count == PEND_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_req_valid && !w_full;
    // The head is popped straight into the bus registers on leaving idle.
    assign w_pop   = (r_state == StIdle) && !w_empty;

    // Next-state and pulse generation
    always_comb begin
        w_state_next   = r_state;
        w_to_cnt_next  = r_to_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                // Ack during issue is stale and deliberately not looked at.
                w_to_cnt_next  = '0;
                w_gap_cnt_next = '0;
                if (r_addr == ACK_ADDR) begin
                    w_state_next = StWaitAck;
                end else begin
                    w_state_next = StGap;
                    w_done_next  = 1'b1;
                end
            end
            StWaitAck: begin
                if (i_ack) begin
                    // Ack wins even on the final timeout cycle.
                    w_state_next   = StGap;
                    w_done_next    = 1'b1;
                    w_gap_cnt_next = '0;
                end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    w_state_next   = StGap;
                    w_err_next     = 1'b1;
                    w_gap_cnt_next = '0;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
            end
            StGap: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_next = StIdle;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM and counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_to_cnt  <= w_to_cnt_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
            if (w_pop) begin
                {r_addr, r_data} <= r_mem[r_rd_ptr];
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PEND_W'(1);
                2'b01:   r_count <= r_count - PEND_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_mem[r_wr_ptr] <= {i_req_addr, i_req_data};
        end
    end

    assign o_req_ready = !w_full;
    assign o_valid     = (r_state == StIssue);
    assign o_addr      = r_addr;
    assign o_data      = r_data;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_busy      = (r_state != StIdle);
    assign o_pending   = r_count;

endmodule

// File: tb/tb_config_master.sv
// -----------------------------------------------------------------------------
// tb_config_master
//   Drives config_master from per-cycle stimulus tables (a directed prefix
//   followed by random traffic) and checks every output on every cycle against
//   a transaction-level model: when a write is popped, its whole timeline
//   (valid, done/err, end of gap) is computed from the ack table up front.
// -----------------------------------------------------------------------------
module tb_config_master;

    localparam int N    = 2000;
    localparam int T    = 16;
    localparam int G    = 2;
    localparam int DEPTH = 4;
    localparam int ACKA = 2;
    localparam int DIR  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_addr = 2'd0;
    logic [1:0] req_data = 2'd0;
    logic       valid;
    logic [1:0] addr, data;
    logic       ack = 1'b0;
    logic       done, err, busy;
    logic [2:0] pending;

    config_master dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_valid     (valid),
        .o_addr      (addr),
        .o_data      (data),
        .i_ack       (ack),
        .o_done      (done),
        .o_err       (err),
        .o_busy      (busy),
        .o_pending   (pending)
    );

    always #5 clk = ~clk;

    // Stimulus tables, indexed by cycle
    bit         rst_t [N];
    bit         rv_t  [N];
    logic [1:0] ra_t  [N];
    logic [1:0] rd_t  [N];
    bit         ack_t [N + T + 8];

    int vectors = 0;
    int miscompares = 0;

    // Model state
    logic [3:0] q[$];
    int         v_cyc = -1, done_cyc = -1, err_cyc = -1, idle_cyc = 0;
    logic [1:0] ea = 2'd0, ed = 2'd0;
    bit         model_ok = 1'b0;

    task automatic chk(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    // Apply the effect of cycle n's inputs at the edge closing cycle n.
    task automatic model_step(input int n);
        int sz;
        int found;
        if (rst_t[n]) begin
            q.delete();
            v_cyc    = -1;
            done_cyc = -1;
            err_cyc  = -1;
            idle_cyc = n + 1;
            ea       = 2'd0;
            ed       = 2'd0;
            model_ok = 1'b1;
        end else begin
            sz = q.size();
            if (n >= idle_cyc && sz > 0) begin
                {ea, ed} = q.pop_front();
                v_cyc = n + 1;
                if (int'(ea) != ACKA) begin
                    done_cyc = v_cyc + 1;
                    err_cyc  = -1;
                    idle_cyc = v_cyc + 1 + G;
                end else begin
                    found = -1;
                    for (int j = 1; j <= T; j++) begin
                        if (found < 0 && ack_t[v_cyc + j]) found = v_cyc + j;
                    end
                    if (found >= 0) begin
                        done_cyc = found + 1;
                        err_cyc  = -1;
                        idle_cyc = found + 1 + G;
                    end else begin
                        done_cyc = -1;
                        err_cyc  = v_cyc + T + 1;
                        idle_cyc = v_cyc + T + 1 + G;
                    end
                end
            end
            if (rv_t[n] && sz < DEPTH) q.push_back({ra_t[n], rd_t[n]});
        end
    endtask

    task automatic compare(input int n);
        bit exp_busy;
        exp_busy = (v_cyc >= 0) && (n >= v_cyc) && (n < idle_cyc);
        chk("valid",   n, 32'(valid),     32'(n == v_cyc));
        chk("addr",    n, 32'(addr),      32'(ea));
        chk("data",    n, 32'(data),      32'(ed));
        chk("done",    n, 32'(done),      32'(n == done_cyc));
        chk("err",     n, 32'(err),       32'(n == err_cyc));
        chk("busy",    n, 32'(busy),      32'(exp_busy));
        chk("pending", n, 32'(pending),   32'(q.size()));
        chk("ready",   n, 32'(req_ready), 32'(q.size() < DEPTH));
        chk("done_err_excl", n, 32'(done && err), 32'd0);
    endtask

    // Hand-derived expectations for the directed prefix
    task automatic literals(input int n);
        case (n)
            2: begin
                chk("lit_rst_ready", n, 32'(req_ready), 32'd1);
                chk("lit_rst_pend",  n, 32'(pending),   32'd0);
                chk("lit_rst_busy",  n, 32'(busy),      32'd0);
                chk("lit_rst_valid", n, 32'(valid),     32'd0);
            end
            3:   chk("lit_t1_pend", n, 32'(pending), 32'd1);
            4: begin
                chk("lit_t1_valid", n, 32'(valid), 32'd1);
                chk("lit_t1_addr",  n, 32'(addr),  32'd2);
                chk("lit_t1_data",  n, 32'(data),  32'd1);
            end
            6: begin
                chk("lit_t1_done", n, 32'(done), 32'd1);
                chk("lit_t1_err",  n, 32'(err),  32'd0);
            end
            8:   chk("lit_t1_idle", n, 32'(busy), 32'd0);
            11: begin
                chk("lit_t3_valid", n, 32'(valid), 32'd1);
                chk("lit_t3_data",  n, 32'(data),  32'd3);
            end
            12: begin
                chk("lit_t3_done",  n, 32'(done),  32'd1);
                chk("lit_t3_novld", n, 32'(valid), 32'd0);
            end
            14:  chk("lit_t3_gap", n, 32'(valid), 32'd0);
            15: begin
                chk("lit_t3_valid2", n, 32'(valid), 32'd1);
                chk("lit_t3_data2",  n, 32'(data),  32'd0);
            end
            36: begin
                chk("lit_t6_done", n, 32'(done), 32'd1);
                chk("lit_t6_err",  n, 32'(err),  32'd0);
            end
            58: begin
                chk("lit_t2_err",  n, 32'(err),  32'd1);
                chk("lit_t2_done", n, 32'(done), 32'd0);
            end
            59:  chk("lit_t2_busy", n, 32'(busy), 32'd1);
            60:  chk("lit_t2_idle", n, 32'(busy), 32'd0);
            66: begin
                chk("lit_t4_full",  n, 32'(pending),   32'd4);
                chk("lit_t4_ready", n, 32'(req_ready), 32'd0);
            end
            83:  chk("lit_t4_resume", n, 32'(req_ready), 32'd1);
            84:  chk("lit_t4_refill", n, 32'(pending),   32'd4);
            190: chk("lit_t5_pend", n, 32'(pending), 32'd3);
            193: begin
                chk("lit_t5_pend0", n, 32'(pending), 32'd0);
                chk("lit_t5_busy0", n, 32'(busy),    32'd0);
                chk("lit_t5_vld0",  n, 32'(valid),   32'd0);
            end
            204: chk("lit_t5_noerr", n, 32'(err), 32'd0);
            default: ;
        endcase
    endtask

    initial begin
        for (int n = 0; n < N; n++) begin
            rst_t[n] = ($urandom_range(299) == 0);
            rv_t[n]  = 1'($urandom_range(1));
            ra_t[n]  = 2'($urandom_range(3));
            rd_t[n]  = 2'($urandom_range(3));
        end
        for (int n = 0; n < N + T + 8; n++) ack_t[n] = ($urandom_range(5) == 0);

        // Directed prefix
        for (int n = 0; n < DIR; n++) begin
            rst_t[n] = 1'b0; rv_t[n] = 1'b0; ra_t[n] = 2'd0; rd_t[n] = 2'd0; ack_t[n] = 1'b0;
        end
        rst_t[0] = 1'b1; rst_t[1] = 1'b1;
        rv_t[2]  = 1'b1; ra_t[2]  = 2'd2; rd_t[2]  = 2'd1; ack_t[5] = 1'b1;
        rv_t[9]  = 1'b1; ra_t[9]  = 2'd1; rd_t[9]  = 2'd3;
        rv_t[10] = 1'b1; ra_t[10] = 2'd1; rd_t[10] = 2'd0;
        rv_t[17] = 1'b1; ra_t[17] = 2'd2; rd_t[17] = 2'd3;
        ack_t[19] = 1'b1; ack_t[35] = 1'b1;
        rv_t[39] = 1'b1; ra_t[39] = 2'd2; rd_t[39] = 2'd2; ack_t[41] = 1'b1;
        for (int n = 61; n <= 65; n++) begin
            rv_t[n] = 1'b1; ra_t[n] = 2'd2; rd_t[n] = 2'(n - 61);
        end
        for (int n = 66; n <= 83; n++) begin
            rv_t[n] = 1'b1; ra_t[n] = 2'd2; rd_t[n] = 2'd1;
        end
        for (int n = 185; n <= 188; n++) begin
            rv_t[n] = 1'b1; ra_t[n] = 2'd2; rd_t[n] = 2'(n - 185);
        end
        rst_t[192] = 1'b1;

        for (int n = 0; n < N; n++) begin
            @(posedge clk);
            if (n > 0) model_step(n - 1);
            #1;
            rst       = rst_t[n];
            req_valid = rv_t[n];
            req_addr  = ra_t[n];
            req_data  = rd_t[n];
            ack       = ack_t[n];
            @(negedge clk);
            if (model_ok) compare(n);
            literals(n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
